// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and sizing helper for the seven-segment scan controller
package seg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;
    localparam int         MAX_DIGITS = 8;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seven_disp_decoder.sv
// rtl/seven_disp_decoder.sv - hex nibble to active-low {a,b,c,d,e,f,g} segment pattern
module seven_disp_decoder (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure lookup; segment bit 6 is 'a', bit 0 is 'g', 0 lights the segment.
    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit multiplexed seven-segment scan controller; SEG_LZ_BLANK_EN enables leading-zero blanking
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [31:0] wdata,
    input  logic [7:0]  wdp,
    output logic        busy,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CNT_W = clog2(SCAN_DIV);
    localparam int IDX_W = clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [31:0]      pdata;
    logic [7:0]       pdp;
    logic [31:0]      ddata;
    logic [7:0]       ddp;

    logic             wrap;
    logic             commit;
    logic [2:0]       sel;
    logic [3:0]       nib;
    logic [6:0]       dec_seg;
    logic             digit_on;
    logic [7:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    assign wrap   = (cnt == CNT_LAST);
    assign commit = wrap && (idx == IDX_LAST);
    assign sel    = 3'(idx);
    assign nib    = ddata[{sel, 2'b00} +: 4];

    // Prescaler and digit index: each digit holds for SCAN_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending/displayed value: new data only reaches the display at the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdata <= '0;
            pdp   <= '0;
            ddata <= '0;
            ddp   <= '0;
            busy  <= 1'b0;
        end else if (commit) begin
            if (wr) begin
                ddata <= wdata;
                ddp   <= wdp;
            end else if (busy) begin
                ddata <= pdata;
                ddp   <= pdp;
            end
            busy <= 1'b0;
        end else if (wr) begin
            pdata <= wdata;
            pdp   <= wdp;
            busy  <= 1'b1;
        end
    end

    seven_disp_decoder u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    logic [7:0] lz_blank;
    logic       lz_zero;

    // A digit goes dark when it and every digit above it holds zero with no decimal point.
    always_comb begin
        lz_blank = '0;
        lz_zero  = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
            if (k < N_DIGITS) begin
                lz_zero     = lz_zero && (ddata[4*k +: 4] == 4'h0);
                lz_blank[k] = lz_zero && !ddp[k];
            end
        end
        digit_on = !lz_blank[sel];
    end
`else
    assign digit_on = 1'b1;
`endif

    // Next-cycle pin values for the digit currently selected.
    always_comb begin
        an_nxt  = AN_ALL_OFF;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        if (digit_on) begin
            an_nxt  = ~(8'b1 << sel);
            seg_nxt = dec_seg;
            dp_nxt  = ~ddp[sel];
        end
    end

    // Registered pin drivers; frame_tick marks the first cycle of digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= AN_ALL_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_tick <= commit;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with a frame-level reference model
module tb_seg_scan_ctrl;

    localparam int S = 4;
    localparam int N = 8;
    localparam int FRAME = S * N;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  wdp;
    logic        busy;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .wdata      (wdata),
        .wdp        (wdp),
        .busy       (busy),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] segtab [16];

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;
    vec_t tab [8];

    // reference model state
    int          q;
    logic [31:0] m_disp;
    logic [7:0]  m_dp;
    logic [31:0] m_pend;
    logic [7:0]  m_pdp;
    logic        m_busy;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_ft;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at q=%0d: got %0h expected %0h", name, q, act, exp);
        end
    endtask

    task automatic model_reset();
        q = 0;
        m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_busy = 1'b0;
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] d, input logic [7:0] p);
        int pos;
        int digit;
        logic [3:0] nibv;
        pos   = q % FRAME;
        digit = pos / S;
        nibv  = 4'((m_disp >> (4 * digit)) & 32'hF);
        e_an  = ~(8'b1 << digit);
        e_seg = segtab[nibv];
        e_dp  = ~m_dp[digit];
`ifdef SEG_LZ_BLANK_EN
        if (digit > 0 && (m_disp >> (4 * digit)) == 0 && !m_dp[digit]) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        end
`endif
        e_ft = (pos == FRAME - 1);
        if (pos == FRAME - 1) begin
            if (w) begin
                m_disp = d; m_dp = p;
            end else if (m_busy) begin
                m_disp = m_pend; m_dp = m_pdp;
            end
            m_busy = 1'b0;
        end else if (w) begin
            m_pend = d; m_pdp = p; m_busy = 1'b1;
        end
        q++;
    endtask

    task automatic check_all();
        check("an", {24'h0, an}, {24'h0, e_an});
        check("seg", {25'h0, seg}, {25'h0, e_seg});
        check("dp", {31'h0, dp}, {31'h0, e_dp});
        check("busy", {31'h0, busy}, {31'h0, m_busy});
        check("frame_tick", {31'h0, frame_tick}, {31'h0, e_ft});
    endtask

    // Called at a negedge: apply inputs, clock once, compare at the next negedge.
    task automatic step(input logic w, input logic [31:0] d, input logic [7:0] p);
        wr = w; wdata = d; wdp = p;
        @(posedge clk);
        model_edge(w, d, p);
        @(negedge clk);
        wr = 1'b0;
        check_all();
    endtask

    task automatic idle_to(input int pos);
        for (int i = 0; i < 2 * FRAME && (q % FRAME) != pos; i++) step(1'b0, 32'h0, 8'h0);
    endtask

    initial begin
        segtab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                   7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                   7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        tab[0] = '{8'hFE, 7'b0111000, 1'b0};
        tab[1] = '{8'hFD, 7'b0110000, 1'b1};
        tab[2] = '{8'hFB, 7'b1000010, 1'b1};
        tab[3] = '{8'hF7, 7'b0110001, 1'b1};
        tab[4] = '{8'hEF, 7'b1100000, 1'b1};
        tab[5] = '{8'hDF, 7'b0001000, 1'b1};
        tab[6] = '{8'hBF, 7'b0000100, 1'b1};
        tab[7] = '{8'h7F, 7'b0000000, 1'b1};

        wr = 1'b0; wdata = '0; wdp = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // first cycle shows digit 0 holding 0
        step(1'b0, 32'h0, 8'h0);
        check("first_an", {24'h0, an}, 32'hFE);
        check("first_seg", {25'h0, seg}, 32'h01);
        for (int i = 1; i < 40; i++) step(1'b0, 32'h0, 8'h0);

        // write mid-frame, committed at the boundary, then walk the digit table
        idle_to(5);
        step(1'b1, 32'h89AB_CDEF, 8'h01);
        check("busy_after_wr", {31'h0, busy}, 32'h1);
        idle_to(0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, 8'h0);
            check("tab_an", {24'h0, an}, {24'h0, tab[k].an});
            check("tab_seg", {25'h0, seg}, {25'h0, tab[k].seg});
            check("tab_dp", {31'h0, dp}, {31'h0, tab[k].dp});
            for (int j = 1; j < S; j++) step(1'b0, 32'h0, 8'h0);
        end

        // write on the commit cycle itself
        idle_to(FRAME - 1);
        step(1'b1, 32'h1, 8'h0);
        check("commit_wr_busy", {31'h0, busy}, 32'h0);
        step(1'b0, 32'h0, 8'h0);
        check("commit_wr_seg", {25'h0, seg}, 32'h4F);
        for (int i = 0; i < FRAME; i++) step(1'b0, 32'h0, 8'h0);

        // two writes in one frame: last one wins
        idle_to(3);
        step(1'b1, 32'h1111_1111, 8'h0);
        idle_to(10);
        step(1'b1, 32'h2222_2222, 8'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 32'h0, 8'h0);
            check("never_one", {31'h0, seg == 7'b1001111}, 32'h0);
        end

        // randomized traffic, including small values with leading zeros
        for (int i = 0; i < 400; i++) begin
            logic w;
            logic [31:0] d;
            w = ($urandom_range(0, 7) == 0);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 7));
            step(w, d, 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
        end

        // reset mid-frame while a write is pending
        idle_to(9);
        step(1'b1, 32'h7777_7777, 8'hFF);
        step(1'b0, 32'h0, 8'h0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_an", {24'h0, an}, 32'hFF);
        check("rst_seg", {25'h0, seg}, 32'h7F);
        check("rst_dp", {31'h0, dp}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ft", {31'h0, frame_tick}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1'b0, 32'h0, 8'h0);
            check("post_rst_zero", {25'h0, seg}, 32'h01);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
